// File: rtl/eth_tx_arbiter.sv
// Two-source round-robin arbiter feeding the Ethernet TX serializer, with inter-frame gap.
// Define ETH_TX_ARB_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
module eth_tx_arbiter #(
  parameter int unsigned IFG_CYCLES = 48,
  parameter int unsigned MIN_FRAME  = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] src0_data,
  input  logic       src0_valid,
  input  logic       src0_last,
  output logic       src0_ready,
  input  logic [7:0] src1_data,
  input  logic       src1_valid,
  input  logic       src1_last,
  output logic       src1_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int unsigned GapW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(IFG_CYCLES - 1);

  if (IFG_CYCLES < 1 || MIN_FRAME < 1 || MIN_FRAME > 65535) begin : g_cfg_check
    $error("eth_tx_arbiter: IFG_CYCLES and MIN_FRAME must lie in 1..65535");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StGap  = 2'd3
`ifdef ETH_TX_ARB_PAD_EN
    , StPad = 2'd2
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_ptr_q, rr_ptr_d;  // 1: src1 preferred on a tie
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic [7:0]  sel_data;
  logic        sel_valid;
  logic        sel_last;
  logic        pick_src1;
  logic        enter_gap;
  logic [15:0] cnt_sat;

  assign sel_data  = grant_q[1] ? src1_data  : src0_data;
  assign sel_valid = grant_q[1] ? src1_valid : src0_valid;
  assign sel_last  = grant_q[1] ? src1_last  : src0_last;
  assign cnt_sat   = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign grant     = grant_q;

`ifdef ETH_TX_ARB_PAD_EN
  logic short_frame;
  // True while the byte now on the bus would still leave the frame below MIN_FRAME.
  assign short_frame = ({1'b0, byte_cnt_q} + 17'd1) < 17'(MIN_FRAME);
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    out_data   = 8'h00;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    pick_src1  = 1'b0;
    enter_gap  = 1'b0;
    busy       = (state_q != StIdle);

    case (state_q)
      StIdle: begin
        pick_src1 = src1_valid && (!src0_valid || rr_ptr_q);
        if (src0_valid || src1_valid) begin
          grant_d    = pick_src1 ? 2'b10 : 2'b01;
          rr_ptr_d   = !pick_src1;
          byte_cnt_d = 16'd0;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        out_data   = sel_data;
        out_valid  = sel_valid;
        out_last   = sel_last;
        src0_ready = grant_q[0] & out_ready;
        src1_ready = grant_q[1] & out_ready;
`ifdef ETH_TX_ARB_PAD_EN
        if (short_frame) out_last = 1'b0;
`endif
        if (sel_valid && out_ready) begin
          byte_cnt_d = cnt_sat;
          if (sel_last) begin
            enter_gap = 1'b1;
`ifdef ETH_TX_ARB_PAD_EN
            if (short_frame) begin
              enter_gap = 1'b0;
              state_d   = StPad;
            end
`endif
          end
        end
      end
`ifdef ETH_TX_ARB_PAD_EN
      StPad: begin
        out_valid = 1'b1;
        out_last  = !short_frame;
        if (out_ready) begin
          byte_cnt_d = cnt_sat;
          enter_gap  = !short_frame;
        end
      end
`endif
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_gap) begin
      state_d   = StGap;
      grant_d   = 2'b00;
      gap_cnt_d = GapLoad;
    end

    // Keep the bus quiet for the whole reset assertion, not just after the first edge.
    if (!resetn) begin
      out_valid  = 1'b0;
      out_last   = 1'b0;
      src0_ready = 1'b0;
      src1_ready = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      rr_ptr_q   <= 1'b0;
      byte_cnt_q <= 16'd0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: queue-driven sources, frame-level reference model.
module tb_eth_tx_arbiter;

  localparam int IFG  = 48;
  localparam int MINF = 60;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] src0_data, src1_data, out_data;
  logic       src0_valid, src0_last, src0_ready;
  logic       src1_valid, src1_last, src1_ready;
  logic       out_valid, out_last, out_ready;
  logic [1:0] grant;
  logic       busy;

  always #10 clk = ~clk;

  eth_tx_arbiter #(
    .IFG_CYCLES(IFG),
    .MIN_FRAME (MINF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .src0_data (src0_data),
    .src0_valid(src0_valid),
    .src0_last (src0_last),
    .src0_ready(src0_ready),
    .src1_data (src1_data),
    .src1_valid(src1_valid),
    .src1_last (src1_last),
    .src1_ready(src1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Source queues hold {last, data}; pend queues hold each source's expected output frames.
  logic [8:0] sq0[$], sq1[$], pend0[$], pend1[$];
  logic [9:0] exp_q[$];  // {src, last, data} in expected output order
  bit first0, first1, drop_en, in_gap, rr_tb;
  int ready_mode, hs_count, gap_seen;

  task automatic drive();
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    src0_valid = (sq0.size() != 0) && !(drop_en && !first0 && $urandom_range(0, 3) == 0);
    src0_data  = (sq0.size() != 0) ? sq0[0][7:0] : 8'($urandom);
    src0_last  = (sq0.size() != 0) ? sq0[0][8] : 1'b0;
    src1_valid = (sq1.size() != 0) && !(drop_en && !first1 && $urandom_range(0, 3) == 0);
    src1_data  = (sq1.size() != 0) ? sq1[0][7:0] : 8'($urandom);
    src1_last  = (sq1.size() != 0) ? sq1[0][8] : 1'b0;
  endtask

  task automatic cycle();
    logic [9:0] e;
    logic [1:0] eg;
    @(negedge clk);
    if (in_gap) begin
      if (busy) begin
        gap_seen++;
        n_checks++;
        if (out_valid !== 1'b0 || grant !== 2'b00) begin
          n_fail++;
          $display("FAIL gap_quiet: out_valid=%b grant=%b, required 0 and 00", out_valid, grant);
        end
      end else begin
        n_checks++;
        if (gap_seen != IFG) begin
          n_fail++;
          $display("FAIL gap_length: %0d busy idle clocks, required %0d", gap_seen, IFG);
        end
        in_gap = 1'b0;
      end
    end
    if (resetn && out_valid && out_ready) begin
      hs_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_byte: got data=%h last=%b, required no byte", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e[8:0]) begin
          n_fail++;
          $display("FAIL out_byte: got last=%b data=%h, required last=%b data=%h",
                   out_last, out_data, e[8], e[7:0]);
        end
        eg = e[9] ? 2'b10 : 2'b01;
        n_checks++;
        if (grant !== eg || (e[9] ? src0_ready : src1_ready) !== 1'b0) begin
          n_fail++;
          $display("FAIL grant_owner: got grant=%b rdy0=%b rdy1=%b, required grant=%b idle rdy 0",
                   grant, src0_ready, src1_ready, eg);
        end
        if (e[8]) begin
          in_gap   = 1'b1;
          gap_seen = 0;
        end
      end
    end
    if (src0_valid && src0_ready) begin
      first0 = sq0[0][8];
      void'(sq0.pop_front());
    end
    if (src1_valid && src1_ready) begin
      first1 = sq1[0][8];
      void'(sq1.pop_front());
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_model();
    sq0.delete(); sq1.delete(); pend0.delete(); pend1.delete(); exp_q.delete();
    first0 = 1'b1; first1 = 1'b1; in_gap = 1'b0; rr_tb = 1'b0;
    drop_en = 1'b0; ready_mode = 0; hs_count = 0; gap_seen = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_model();
    drive();
    repeat (2) cycle();
    resetn = 1'b1;
  endtask

  // Expected output: source bytes, zero padding when enabled, out_last on the final byte.
  task automatic send_frame(input bit s, input int len);
    int plen;
    logic [7:0] b;
    plen = len;
`ifdef ETH_TX_ARB_PAD_EN
    if (len < MINF) plen = MINF;
`endif
    for (int i = 0; i < plen; i++) begin
      b = (i < len) ? 8'($urandom) : 8'h00;
      if (i < len) begin
        if (s) sq1.push_back({(i == len - 1), b});
        else   sq0.push_back({(i == len - 1), b});
      end
      if (s) pend1.push_back({(i == plen - 1), b});
      else   pend0.push_back({(i == plen - 1), b});
    end
  endtask

  task automatic move_frame(input bit s);
    logic [8:0] e;
    do begin
      e = s ? pend1.pop_front() : pend0.pop_front();
      exp_q.push_back({s, e});
    end while (!e[8]);
  endtask

  // Round robin over whole frames, assuming every queued frame is pending at arbitration time.
  task automatic order_rr();
    bit s;
    while (pend0.size() != 0 || pend1.size() != 0) begin
      if (pend0.size() != 0 && pend1.size() != 0) s = rr_tb;
      else s = (pend1.size() != 0);
      move_frame(s);
      rr_tb = !s;
    end
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || sq0.size() != 0 || sq1.size() != 0 || in_gap) && n < budget) begin
      cycle();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL timeout: %0d bytes still expected after %0d clocks, required 0",
               exp_q.size(), n);
    end
  endtask

  task automatic check_count(input string name, input int exp_n);
    n_checks++;
    if (hs_count != exp_n) begin
      n_fail++;
      $display("FAIL %s: %0d handshakes, required %0d", name, hs_count, exp_n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    resetn = 1'b0;
    sq0.push_back({1'b0, 8'hA5});
    sq1.push_back({1'b1, 8'h5A});
    drive();
    repeat (2) cycle();
    #2;
    n_checks++;
    if ({grant, busy, out_valid, out_last, src0_ready, src1_ready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b busy=%b ov=%b ol=%b r0=%b r1=%b, required all 0",
               grant, busy, out_valid, out_last, src0_ready, src1_ready);
    end
    clear_model();
    drive();
    resetn = 1'b1;
    repeat (3) cycle();
    #2;
    n_checks++;
    if (busy !== 1'b0 || grant !== 2'b00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b grant=%b ov=%b, required 0/00/0",
               busy, grant, out_valid);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    send_frame(1'b0, 64);
    order_rr();
    run_until_done(2000);
    check_count("single_frame_len", 64);
  endtask

  task automatic test_arbitration();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      send_frame(1'b0, $urandom_range(10, 40));
      send_frame(1'b1, $urandom_range(10, 40));
      order_rr();
      run_until_done(4000);
    end
  endtask

  task automatic test_pad();
    do_reset();
    send_frame(1'b1, 42);
    order_rr();
    run_until_done(2000);
`ifdef ETH_TX_ARB_PAD_EN
    check_count("pad_len", MINF);
`else
    check_count("pad_len", 42);
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_mode = 1;
    send_frame(1'b0, 20);
    order_rr();
    run_until_done(2000);
`ifdef ETH_TX_ARB_PAD_EN
    check_count("toggle_handshakes", MINF);
`else
    check_count("toggle_handshakes", 20);
`endif
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    do_reset();
    send_frame(1'b0, 64);
    order_rr();
    while (hs_count < 10 && n < 500) begin
      cycle();
      n++;
    end
    check_count("bytes_before_reset", 10);
    resetn = 1'b0;
    cycle();
    #2;
    n_checks++;
    if (grant !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: grant=%b ov=%b busy=%b, required 00/0/0",
               grant, out_valid, busy);
    end
    clear_model();
    drive();
    resetn = 1'b1;
    send_frame(1'b1, 30);
    order_rr();
    run_until_done(2000);
  endtask

  task automatic test_random();
    do_reset();
    drop_en    = 1'b1;
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0, $urandom_range(1, 80));
      send_frame(1'b1, $urandom_range(1, 80));
    end
    order_rr();
    run_until_done(8000);
  endtask

  initial begin
    resetn    = 1'b0;
    out_ready = 1'b1;
    clear_model();
    drive();
    test_reset();
    test_single_frame();
    test_arbitration();
    test_pad();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
